// File: rtl/cp0_nested_intc.sv
// Nested, vectored interrupt controller beside the CP0 pipeline.
// Edge-triggered sources with per-source masks and fixed priority (higher index wins).
// A hardware stack saves {PC, IE, source index} on each taken interrupt.
// An in-service level blocks equal and lower priorities until its eret.
module cp0_nested_intc #(
  parameter int          NSRC       = 8,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NSRC-1:0]            irq_src,
  output logic                       int_req,
  output logic [31:0]                int_vector,
  input  logic                       int_ack,
  input  logic [31:0]                int_pc,
  input  logic                       eret,
  output logic [31:0]                epc_out,
  input  logic                       csr_we,
  input  logic [4:0]                 csr_waddr,
  input  logic [31:0]                csr_wdata,
  input  logic [4:0]                 csr_raddr,
  output logic [31:0]                csr_rdata,
  output logic [$clog2(DEPTH+1)-1:0] nest_level
);

  localparam int LW    = $clog2(DEPTH+1);
  localparam int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << SW;

  typedef struct packed {
    logic [31:0] pc;
    logic        ie;
    logic [3:0]  idx;
  } frame_t;

  frame_t          stk [SLOTS];
  logic [NSRC-1:0] sync1, sync2, prev, pending, mask;
  logic [NSRC-1:0] rise, ceil_mask, eligible, clr_bits, ack_clr, req_oh, sel_oh;
  logic            ie;
  logic [LW-1:0]   depth;
  logic [3:0]      req_idx, sel_idx;
  logic [SW-1:0]   top_s, push_s;
  frame_t          top_f;
  logic [4:0]      cur_pri;
  logic            wr_status, wr_cause, wr_epc, eret_eff, ack_eff, ie_wr0, drop, raise;
  logic [31:0]     vec_nxt;
  logic            unused_ok;

  assign unused_ok = ^csr_wdata;

  // An empty stack still exposes entry 0 as its top.
  assign top_s   = (depth == '0) ? '0 : SW'(depth - 1'b1);
  assign push_s  = SW'(depth);
  assign top_f   = stk[top_s];
  assign cur_pri = (depth == '0) ? 5'd0 : {1'b0, top_f.idx} + 5'd1;

  assign rise      = sync2 & ~prev;
  assign wr_status = csr_we && (csr_waddr == 5'd12);
  assign wr_cause  = csr_we && (csr_waddr == 5'd13);
  assign wr_epc    = csr_we && (csr_waddr == 5'd14);
  assign eret_eff  = eret && (depth != '0);
  // When eret and ack coincide, eret is taken and the ack is dropped.
  assign ack_eff   = int_req && int_ack && !eret_eff;
  assign clr_bits  = wr_cause ? csr_wdata[8 +: NSRC] : '0;
  assign ie_wr0    = wr_status && !csr_wdata[0];
  assign req_oh    = NSRC'(1) << req_idx;
  assign sel_oh    = NSRC'(1) << sel_idx;
  assign ack_clr   = ack_eff ? req_oh : '0;
  assign drop      = int_req && (ie_wr0 || (|(clr_bits & req_oh)));
  // Withdraw conditions also suppress a raise in the same cycle.
  // Otherwise a request could come up and then be stuck.
  assign raise     = !int_req && ie && (|eligible) && (depth < LW'(DEPTH)) && !eret
                     && !ie_wr0 && !(|(clr_bits & sel_oh));
  assign vec_nxt   = VEC_BASE + 32'(sel_idx) * VEC_STRIDE;

  // Priority ceiling and highest-index selection among eligible sources.
  always_comb begin
    ceil_mask = '0;
    for (int i = 0; i < NSRC; i++) ceil_mask[i] = (5'(i) >= cur_pri);
    eligible = pending & mask & ceil_mask;
    sel_idx  = '0;
    for (int i = 0; i < NSRC; i++) if (eligible[i]) sel_idx = 4'(i);
  end

  // Synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Pending, mask and IE. A new edge wins over any clear.
  // Eret's IE restore wins over ack, and ack wins over a CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '0;
      ie      <= 1'b0;
    end else begin
      pending <= (pending & ~clr_bits & ~ack_clr) | rise;
      if (wr_status) mask <= csr_wdata[8 +: NSRC];
      if (eret_eff)       ie <= top_f.ie;
      else if (ack_eff)   ie <= 1'b0;
      else if (wr_status) ie <= csr_wdata[0];
    end
  end

  // Save stack. An EPC write lands on the pre-push top.
  // At depth 0 that is also the push slot, and the push wins there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      for (int i = 0; i < SLOTS; i++) stk[i] <= '0;
    end else begin
      if (wr_epc) stk[top_s].pc <= csr_wdata;
      if (eret_eff) begin
        depth <= depth - 1'b1;
      end else if (ack_eff) begin
        stk[push_s] <= {int_pc, ie, req_idx};
        depth       <= depth + 1'b1;
      end
    end
  end

  // Request register. The index and vector stay frozen while the request is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_req    <= 1'b0;
      int_vector <= '0;
      req_idx    <= '0;
    end else if (ack_eff || eret_eff || drop) begin
      int_req <= 1'b0;
    end else if (raise) begin
      int_req    <= 1'b1;
      req_idx    <= sel_idx;
      int_vector <= vec_nxt;
    end
  end

  // CSR readback: STATUS, CAUSE and EPC. Other addresses read 0.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      5'd12: begin
        csr_rdata[0]         = ie;
        csr_rdata[8 +: NSRC] = mask;
      end
      5'd13: begin
        csr_rdata[8 +: NSRC] = pending;
        csr_rdata[27:24]     = (depth != '0) ? top_f.idx : 4'd0;
      end
      5'd14:   csr_rdata = top_f.pc;
      default: csr_rdata = '0;
    endcase
  end

  assign epc_out    = top_f.pc;
  assign nest_level = depth;

endmodule

// File: tb/tb_cp0_nested_intc.sv
// Scoreboard bench for cp0_nested_intc.
// Expected vectors are queued when sources fire and are checked when int_req rises.
// Saved PCs are kept in a LIFO model that is popped on each eret.
module tb_cp0_nested_intc;
  localparam int NSRC  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NSRC-1:0] irq_src = '0;
  logic            int_req;
  logic [31:0]     int_vector;
  logic            int_ack = 1'b0;
  logic [31:0]     int_pc = '0;
  logic            eret = 1'b0;
  logic [31:0]     epc_out;
  logic            csr_we = 1'b0;
  logic [4:0]      csr_waddr = '0;
  logic [31:0]     csr_wdata = '0;
  logic [4:0]      csr_raddr = '0;
  logic [31:0]     csr_rdata;
  logic [2:0]      nest_level;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] vec_q[$];
  logic [31:0] epc_q[$];
  logic [31:0] rd;

  cp0_nested_intc #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .int_req(int_req),
    .int_vector(int_vector), .int_ack(int_ack), .int_pc(int_pc), .eret(eret),
    .epc_out(epc_out), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .nest_level(nest_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [4:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic pulse(input logic [NSRC-1:0] b);
    irq_src = irq_src | b;
    tick();
    irq_src = irq_src & ~b;
  endtask

  // Waits a bounded number of cycles for a request, then checks it against the scoreboard.
  task automatic wait_req(input string tag, input int maxc);
    int n = 0;
    logic [31:0] e;
    while (!int_req && n < maxc) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(int_req), 32'd1);
    e = (vec_q.size() > 0) ? vec_q.pop_front() : 32'hdead_beef;
    chk({tag, "_vec"}, int_vector, e);
  endtask

  task automatic do_ack(input string tag, input logic [31:0] pc);
    int_ack = 1'b1; int_pc = pc;
    tick();
    int_ack = 1'b0;
    epc_q.push_back(pc);
    chk({tag, "_epc"}, epc_out, pc);
    chk({tag, "_lvl"}, 32'(nest_level), 32'(epc_q.size()));
  endtask

  task automatic do_eret(input string tag, input logic with_ack);
    eret = 1'b1; int_ack = with_ack;
    tick();
    eret = 1'b0; int_ack = 1'b0;
    void'(epc_q.pop_back());
    chk({tag, "_lvl"}, 32'(nest_level), 32'(epc_q.size()));
    if (epc_q.size() > 0) chk({tag, "_epc"}, epc_out, epc_q[$]);
  endtask

  task automatic idle_noreq(input string tag, input int n);
    for (int i = 0; i < n; i++) tick();
    chk(tag, 32'(int_req), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_req", 32'(int_req), 0);
    chk("rst_vec", int_vector, 0);
    chk("rst_epc", epc_out, 0);
    chk("rst_lvl", 32'(nest_level), 0);

    // Single source: 3 -> 0x130
    csr_wr(5'd12, 32'h0000_0801);
    vec_q.push_back(32'h130);
    pulse(8'h08);
    wait_req("s3", 4);
    do_ack("s3_ack", 32'h400);
    csr_rd(5'd12, rd); chk("s3_ie0", rd & 32'h1, 0);
    csr_rd(5'd13, rd); chk("s3_cause", rd, 32'h0300_0000);
    csr_rd(5'd14, rd); chk("s3_epc_csr", rd, 32'h400);
    do_eret("s3_eret", 1'b0);
    csr_rd(5'd12, rd); chk("s3_ie1", rd, 32'h0000_0801);
    idle_noreq("s3_quiet", 4);

    // Priority and nesting
    csr_wr(5'd12, 32'h0000_FF01);
    vec_q.push_back(32'h150);
    pulse(8'h24);
    wait_req("p5", 6);
    do_ack("p5_ack", 32'h500);
    csr_wr(5'd12, 32'h0000_FF01);
    idle_noreq("p2_ceil", 4);
    vec_q.push_back(32'h170);
    pulse(8'h80);
    wait_req("p7", 6);
    do_ack("p7_ack", 32'h600);
    csr_rd(5'd13, rd); chk("p7_cause", rd, 32'h0700_0400);
    csr_wr(5'd12, 32'h0000_FF01);
    pulse(8'h10);
    idle_noreq("p4_blk2", 5);
    do_eret("p7_eret", 1'b0);
    idle_noreq("p4_blk1", 4);
    vec_q.push_back(32'h140);
    do_eret("p5_eret", 1'b0);
    wait_req("p4", 3);
    do_ack("p4_ack", 32'h700);
    vec_q.push_back(32'h120);
    do_eret("p4_eret", 1'b0);
    wait_req("p2", 3);
    // A CAUSE write of 1 to the requested source withdraws the request
    csr_wr(5'd13, 32'h0000_0400);
    chk("wd_req", 32'(int_req), 0);
    csr_rd(5'd13, rd); chk("wd_cause", rd, 0);
    idle_noreq("wd_quiet", 3);

    // Stack full at DEPTH, LIFO pops, eret dropping a live request, eret+ack
    for (int k = 1; k <= DEPTH; k++) begin
      logic [NSRC-1:0] b;
      b = NSRC'(1) << k;
      vec_q.push_back(32'h100 + 32'(k) * 32'h10);
      pulse(b);
      wait_req("fl", 6);
      do_ack("fl_ack", 32'h1000 + 32'(k) * 4);
      csr_wr(5'd12, 32'h0000_FF01);
    end
    pulse(8'h80);
    idle_noreq("full_blk", 5);
    csr_rd(5'd13, rd); chk("full_pend", rd & 32'h0000_FF00, 32'h0000_8000);
    vec_q.push_back(32'h170);
    do_eret("full_eret", 1'b0);
    wait_req("f7", 3);
    vec_q.push_back(32'h170);
    do_eret("drop_eret", 1'b0);
    chk("drop_req", 32'(int_req), 0);
    wait_req("f7b", 3);
    vec_q.push_back(32'h170);
    do_eret("ea_eret", 1'b1);
    csr_rd(5'd13, rd); chk("ea_pend", rd & 32'h0000_FF00, 32'h0000_8000);
    wait_req("f7c", 3);
    do_ack("f7_ack", 32'h2000);
    do_eret("f7_eret", 1'b0);
    do_eret("f1_eret", 1'b0);

    // Masking: a pending source with mask 0 requests as soon as it is unmasked
    csr_wr(5'd12, 32'h0000_0001);
    pulse(8'h40);
    idle_noreq("m_blk", 4);
    csr_rd(5'd13, rd); chk("m_pend", rd, 32'h0000_4000);
    csr_wr(5'd12, 32'h0000_4001);
    vec_q.push_back(32'h160);
    wait_req("m6", 1);
    do_ack("m6_ack", 32'h3000);
    do_eret("m6_eret", 1'b0);

    // Reset mid-operation: depth 2 with a request up
    csr_wr(5'd12, 32'h0000_FF01);
    for (int k = 0; k < 2; k++) begin
      logic [NSRC-1:0] b;
      b = NSRC'(1) << k;
      vec_q.push_back(32'h100 + 32'(k) * 32'h10);
      pulse(b);
      wait_req("r", 6);
      do_ack("r_ack", 32'h4000 + 32'(k));
      csr_wr(5'd12, 32'h0000_FF01);
    end
    vec_q.push_back(32'h120);
    pulse(8'h04);
    wait_req("r2", 6);
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    epc_q.delete();
    chk("mr_req", 32'(int_req), 0);
    chk("mr_vec", int_vector, 0);
    chk("mr_epc", epc_out, 0);
    chk("mr_lvl", 32'(nest_level), 0);
    csr_rd(5'd12, rd); chk("mr_status", rd, 0);
    csr_rd(5'd13, rd); chk("mr_cause", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
